// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU
// between two valid/ready requesters, with held per-requester responses.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    // requester 0
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_func,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_out,
    output logic             r0_zero,
    // requester 1
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_func,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_out,
    output logic             r1_zero,
    // external ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;      // 0: r0 wins a tie, 1: r1 wins a tie
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       func_q, func_d;
    logic             r0_vld_q, r0_vld_d;
    logic [WIDTH-1:0] r0_out_q, r0_out_d;
    logic             r0_zero_q, r0_zero_d;
    logic             r1_vld_q, r1_vld_d;
    logic [WIDTH-1:0] r1_out_q, r1_out_d;
    logic             r1_zero_q, r1_zero_d;

    // Grant: a lone valid requester wins, a tie goes to the pointer; only in IDLE
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (state_q == IDLE) begin
            if (r0_valid && (!r1_valid || !ptr_q)) begin
                r0_ready = 1'b1;
            end else if (r1_valid) begin
                r1_ready = 1'b1;
            end
        end
    end

    // Next-state: accept in IDLE, capture ALU result in EXEC, hold until consumed in RESP
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        a_d       = a_q;
        b_d       = b_q;
        func_d    = func_q;
        r0_vld_d  = r0_vld_q;
        r0_out_d  = r0_out_q;
        r0_zero_d = r0_zero_q;
        r1_vld_d  = r1_vld_q;
        r1_out_d  = r1_out_q;
        r1_zero_d = r1_zero_q;
        case (state_q)
            IDLE: begin
                if (r0_ready) begin
                    a_d     = r0_a;
                    b_d     = r0_b;
                    func_d  = r0_func;
                    owner_d = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = EXEC;
                end else if (r1_ready) begin
                    a_d     = r1_a;
                    b_d     = r1_b;
                    func_d  = r1_func;
                    owner_d = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!owner_q) begin
                    r0_out_d  = alu_out;
                    r0_zero_d = alu_zero;
                    r0_vld_d  = 1'b1;
                end else begin
                    r1_out_d  = alu_out;
                    r1_zero_d = alu_zero;
                    r1_vld_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (!owner_q && r0_rsp_ready) begin
                    r0_vld_d = 1'b0;
                    state_d  = IDLE;
                end else if (owner_q && r1_rsp_ready) begin
                    r1_vld_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            r0_vld_q  <= 1'b0;
            r0_out_q  <= '0;
            r0_zero_q <= 1'b0;
            r1_vld_q  <= 1'b0;
            r1_out_q  <= '0;
            r1_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            a_q       <= a_d;
            b_q       <= b_d;
            func_q    <= func_d;
            r0_vld_q  <= r0_vld_d;
            r0_out_q  <= r0_out_d;
            r0_zero_q <= r0_zero_d;
            r1_vld_q  <= r1_vld_d;
            r1_out_q  <= r1_out_d;
            r1_zero_q <= r1_zero_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_func     = func_q;
    assign r0_rsp_valid = r0_vld_q;
    assign r0_out       = r0_out_q;
    assign r0_zero      = r0_zero_q;
    assign r1_rsp_valid = r1_vld_q;
    assign r1_out       = r1_out_q;
    assign r1_zero      = r1_zero_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_zero;
    logic [W-1:0] r0_a, r0_b, r0_out;
    logic [2:0]   r0_func;
    logic         r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_zero;
    logic [W-1:0] r1_a, r1_b, r1_out;
    logic [2:0]   r1_func;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [2:0]   alu_func;
    logic         alu_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_func(r0_func), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_out(r0_out), .r0_zero(r0_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_func(r1_func), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_out(r1_out), .r1_zero(r1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
    );

    // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 b<<16, 7 sltu
    always_comb begin
        alu_out = '0;
        case (alu_func)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            3'd6: alu_out = alu_b << 16;
            3'd7: alu_out = {{(W-1){1'b0}}, (alu_a < alu_b)};
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_func = '0; r0_rsp_ready = 1'b1;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_func = '0; r1_rsp_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request until granted, leaves the bench at the negedge of the RESP cycle
    task automatic run_op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] f);
        int n;
        n = 0;
        @(negedge clk);
        if (!who) begin r0_a = a; r0_b = b; r0_func = f; r0_valid = 1'b1; end
        else      begin r1_a = a; r1_b = b; r1_func = f; r1_valid = 1'b1; end
        #1;
        while (!(who ? r1_ready : r0_ready) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (n >= 10) begin bad++; $display("FAIL grant_timeout who=%0d got=0 want=1", who); end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({r0_rsp_valid, r1_rsp_valid, r0_zero, r1_zero, busy, r0_ready, r1_ready} !== 7'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000000",
                {r0_rsp_valid, r1_rsp_valid, r0_zero, r1_zero, busy, r0_ready, r1_ready});
        end
        total++;
        if (r0_out !== '0 || r1_out !== '0) begin
            bad++; $display("FAIL reset_out got=%h/%h want=0/0", r0_out, r1_out);
        end
        total++;
        if (alu_a !== '0 || alu_b !== '0 || alu_func !== 3'd0) begin
            bad++; $display("FAIL reset_alu got=%h/%h/%0d want=0/0/0", alu_a, alu_b, alu_func);
        end
        // rsp_ready with nothing pending must not start anything
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL idle_rsp_ready got=%b%b want=00", busy, r0_rsp_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        r0_rsp_ready = 1'b0;
        r0_a = 32'd5; r0_b = 32'd3; r0_func = 3'd0; r0_valid = 1'b1;
        #1;
        total++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL single_ready got=%b%b want=10", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b1 || r0_rsp_valid !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd3) begin
            bad++; $display("FAIL single_exec got=busy%b vld%b a%h b%h want=busy1 vld0 a5 b3",
                busy, r0_rsp_valid, alu_a, alu_b);
        end
        @(negedge clk); #1;
        total++;
        if (r0_rsp_valid !== 1'b1 || r0_out !== 32'd8 || r0_zero !== 1'b0 || r1_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_rsp got=vld%b out%h z%b r1vld%b want=vld1 out8 z0 r1vld0",
                r0_rsp_valid, r0_out, r0_zero, r1_rsp_valid);
        end
        r0_rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r0_out !== 32'd8) begin
            bad++; $display("FAIL single_release got=busy%b vld%b out%h want=busy0 vld0 out8",
                busy, r0_rsp_valid, r0_out);
        end
    endtask

    task automatic test_both();
        apply_reset();
        r0_a = 32'd7;    r0_b = 32'd7;    r0_func = 3'd1; r0_valid = 1'b1;
        r1_a = 32'hF0;   r1_b = 32'h3C;   r1_func = 3'd2; r1_valid = 1'b1;
        #1;
        total++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL both_first_grant got=%b%b want=10", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        total++;
        if (r0_rsp_valid !== 1'b1 || r0_out !== 32'd0 || r0_zero !== 1'b1 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL both_r0_rsp got=vld%b out%h z%b r1rdy%b want=vld1 out0 z1 r1rdy0",
                r0_rsp_valid, r0_out, r0_zero, r1_ready);
        end
        @(negedge clk); #1;
        total++;
        if (r1_ready !== 1'b1) begin
            bad++; $display("FAIL both_second_grant got=%b want=1", r1_ready);
        end
        @(posedge clk); #1;
        r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        total++;
        if (r1_rsp_valid !== 1'b1 || r1_out !== 32'h30 || r1_zero !== 1'b0 ||
            r0_out !== 32'd0 || r0_zero !== 1'b1 || r0_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL both_r1_rsp got=vld%b out%h z%b r0out%h r0z%b r0vld%b want=1 30 0 0 1 0",
                r1_rsp_valid, r1_out, r1_zero, r0_out, r0_zero, r0_rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ng;
        int both;
        bit who [4];
        int at  [4];
        ng = 0; both = 0;
        apply_reset();
        r0_a = 32'd1;  r0_b = 32'd2; r0_func = 3'd0; r0_valid = 1'b1;
        r1_a = 32'd10; r1_b = 32'd3; r1_func = 3'd1; r1_valid = 1'b1;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (r0_ready && r1_ready) both++;
            if (r0_ready)      begin who[ng] = 1'b0; at[ng] = c; ng++; end
            else if (r1_ready) begin who[ng] = 1'b1; at[ng] = c; ng++; end
            @(negedge clk);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        total++;
        if (ng !== 4 || both !== 0) begin
            bad++; $display("FAIL b2b_count got=%0d both=%0d want=4 both=0", ng, both);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (who[k] !== k[0] || at[k] !== 3 * k) begin
                    bad++; $display("FAIL b2b_grant%0d got=r%0d@%0d want=r%0d@%0d",
                        k, who[k], at[k], k[0], 3 * k);
                end
            end
        end
        @(negedge clk); #1;
        total++;
        if (r0_out !== 32'd3 || r1_out !== 32'd7 || r1_rsp_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_results got=%h/%h vld%b want=3/7 vld1", r0_out, r1_out, r1_rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        apply_reset();
        r1_rsp_ready = 1'b0;
        run_op(1'b1, 32'd0, 32'h1234, 3'd6);
        r0_a = 32'd1; r0_b = 32'd1; r0_func = 3'd0; r0_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (r1_rsp_valid !== 1'b1 || r1_out !== 32'h12340000 || r0_ready !== 1'b0 ||
                busy !== 1'b1 || r0_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=vld%b out%h r0rdy%b busy%b want=1 12340000 0 1",
                    k, r1_rsp_valid, r1_out, r0_ready, busy);
            end
            @(negedge clk); #1;
        end
        r1_rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0 || r1_rsp_valid !== 1'b0 || r1_out !== 32'h12340000 || r0_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=busy%b vld%b out%h r0rdy%b want=0 0 12340000 1",
                busy, r1_rsp_valid, r1_out, r0_ready);
        end
        total++;
        if (alu_b !== 32'h1234 || alu_func !== 3'd6) begin
            bad++; $display("FAIL bp_alu_hold got=%h/%0d want=1234/6", alu_b, alu_func);
        end
        r0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_op(1'b0, 32'd5, 32'd3, 3'd0);
        total++;
        if (r0_out !== 32'd8) begin
            bad++; $display("FAIL rm_setup got=%h want=8", r0_out);
        end
        @(negedge clk);
        r0_a = 32'd11; r0_b = 32'd0; r0_func = 3'd3; r0_valid = 1'b1;
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0 ||
            r0_out !== '0 || alu_a !== '0 || alu_func !== 3'd0) begin
            bad++; $display("FAIL rm_cleared got=busy%b vld%b%b out%h a%h f%0d want=0 00 0 0 0",
                busy, r0_rsp_valid, r1_rsp_valid, r0_out, alu_a, alu_func);
        end
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        total++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL rm_pointer got=%b%b want=10", r0_ready, r1_ready);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_func_codes();
        apply_reset();
        run_op(1'b0, 32'd9, 32'd4, 3'd7);
        total++;
        if (r0_out !== 32'd0 || r0_zero !== 1'b1) begin
            bad++; $display("FAIL func7 got=%h z%b want=0 z1", r0_out, r0_zero);
        end
        run_op(1'b1, 32'd2, 32'd9, 3'd5);
        total++;
        if (r1_out !== 32'd1 || r1_zero !== 1'b0) begin
            bad++; $display("FAIL func5 got=%h z%b want=1 z0", r1_out, r1_zero);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_func = '0; r0_rsp_ready = 1'b0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_func = '0; r1_rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_func_codes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: r0 (e.g. main datapath) and r1 (e.g. address/branch helper).
- Round-robin arbitration with valid/ready request handshakes and held responses.
- Registers the operands, drives the external ALU for one cycle, then captures out/zero_flag into the granted requester's response registers.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU's size parameter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  requester 0 has an operation
- r0_ready  output  1  requester 0 operation accepted this cycle
- r0_a  input  WIDTH  operand a
- r0_b  input  WIDTH  operand b
- r0_func  input  3  ALU function code
- r0_rsp_valid  output  1  requester 0 result available
- r0_rsp_ready  input  1  requester 0 consumes result
- r0_out  output  WIDTH  result
- r0_zero  output  1  zero flag of result
- r1_*  same nine signals as r0_*, for requester 1
- alu_a  output  WIDTH  to ALU a
- alu_b  output  WIDTH  to ALU b
- alu_func  output  3  to ALU func
- alu_out  input  WIDTH  from ALU out
- alu_zero  input  1  from ALU zero_flag
- busy  output  1  high in EXEC or RESP

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all flops update on the rising edge of clk.
- Reset values:
  - state IDLE
  - r0/r1 rsp_valid = 0, out = 0, zero = 0
  - operand registers = 0, so alu_a = alu_b = 0 and alu_func = 0
  - busy = 0
  - priority pointer favours r0
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: if only one requester is valid, it wins. If both are valid, the requester named by the priority pointer wins.
  - Only the winner's ready is high; ready is combinational from valid and pointer and is 0 in every other state.
  - On valid&&ready, latch a/b/func and the owner id. Set the pointer to the other requester. Go to EXEC.
  - With no valid requester, the pointer is unchanged.
- EXEC (exactly 1 cycle):
  - alu_a/b/func are driven from the latched registers.
  - At the end of the cycle, alu_out and alu_zero are captured into the owner's out/zero, and owner rsp_valid is set to 1. Go to RESP.
- RESP:
  - Owner rsp_valid, out and zero are held stable until owner rsp_ready = 1.
  - On that edge, rsp_valid is cleared and state returns to IDLE.
  - No request is accepted in RESP, including on the release cycle.
- Latency: accept at cycle T, rsp_valid high from T+2. With rsp_ready tied high, IDLE at T+3 and the next accept is possible at T+3, giving 1 op per 3 cycles.
- Non-owner rsp_valid stays 0; non-owner out/zero retain their last captured values.
- A requester may drop valid before being granted; arbitration re-evaluates every cycle with no penalty.
- alu_a/b/func hold the last latched operands outside EXEC; they change only on accept.
- Result width is WIDTH bits, taken verbatim from the ALU. No reinterpretation of func codes; codes 0..7 are all passed through.
- Reset asserted in any state (including mid-EXEC or RESP) discards the operation and returns every output to its reset value on the next edge.
- rsp_ready asserted while rsp_valid = 0 is ignored.

Test Plan:
- After reset, r0 only: a=5, b=3, func=0 -> r0_ready high at T; r0_rsp_valid high at T+2; r0_out=8, r0_zero=0; r1_rsp_valid stays 0.
- Both valid right after reset: r0 a=7, b=7, func=1 and r1 a=0xF0, b=0x3C, func=2 -> r0 granted first with r0_out=0, r0_zero=1; then r1 granted with r1_out=0x30, r1_zero=0.
- Both held valid continuously for 4 operations, rsp_ready tied high -> grant order r0, r1, r0, r1; accepts spaced exactly 3 cycles apart.
- Backpressure: r1 op func=6, b=0x1234 with r1_rsp_ready low for 5 cycles -> r1_rsp_valid stays high, r1_out=0x12340000 stable, r0_ready=0 despite r0_valid, busy=1; release -> IDLE next cycle.
- Reset pulsed during EXEC -> next cycle busy=0, both rsp_valid=0, outputs 0; a subsequent simultaneous request grants r0 first.
- func=7, a=9, b=4 -> out=0, zero=1. Separately, func=5, a=2, b=9 -> out=1, zero=0.
